nco_phase_accumulator: RTL and testbench

Numerically controlled oscillator front end. It accumulates a frequency tuning word once per sample strobe, adds a phase offset and optional LFSR dither, and truncates the result to a WIDTHT-bit phase `theta`. That phase drives the quarter-wave sine/cosine lookup stage directly downstream. Tuning-word updates use a valid/ready handshake and take effect on a sample boundary, so the mixer never sees a mid-sample frequency change.

---
 rtl/nco_phase_accumulator_if.sv | 41 ++++
 rtl/nco_phase_accumulator.sv | 179 +++++++++++++++++
 tb/tb_nco_phase_accumulator.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/nco_phase_accumulator_if.sv
// Tuning-word handshake, sample strobe and phase output bundle of the NCO
// phase accumulator. The master side feeds tuning words and sample strobes;
// the slave side (the accumulator) returns the truncated phase.
interface nco_phase_accumulator_if #(
    parameter int WIDTHA = 32,
    parameter int WIDTHT = 11
);
    logic              enable;
    logic [WIDTHA-1:0] ftw_data;
    logic              ftw_valid;
    logic              ftw_ready;
    logic [WIDTHT-1:0] pow_data;
    logic              phase_sync;
    logic [WIDTHT-1:0] theta;
    logic              theta_valid;
    logic              wrap;

    modport master (
        output enable,
        output ftw_data,
        output ftw_valid,
        output pow_data,
        output phase_sync,
        input  ftw_ready,
        input  theta,
        input  theta_valid,
        input  wrap
    );

    modport slave (
        input  enable,
        input  ftw_data,
        input  ftw_valid,
        input  pow_data,
        input  phase_sync,
        output ftw_ready,
        output theta,
        output theta_valid,
        output wrap
    );
endinterface

// File: rtl/nco_phase_accumulator.sv
// NCO phase accumulator front end.
// Accumulates the tuning word on each sample strobe, adds optional LFSR
// dither below the truncation point plus a phase offset, and delivers a
// WIDTHT-bit phase two edges after the strobe. New tuning words are parked
// in a pending register and only switched in on a sample boundary.
module nco_phase_accumulator #(
    parameter int WIDTHA = 32,
    parameter int WIDTHT = 11,
    parameter int DITHER = 0
) (
    input  logic                    clock,
    input  logic                    clock_areset_n,
    nco_phase_accumulator_if.slave  bus
);

    // Bits discarded by the phase truncation.
    localparam int LOWW = WIDTHA - WIDTHT;
    // Aligns the 16-bit LFSR so its MSB sits just below half a theta LSB.
    localparam int DSHIFT = (DITHER != 0) ? (WIDTHA - WIDTHT - 17) : 0;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // Handshake state
    logic              pend_r;
    logic [WIDTHA-1:0] ftw_active_r;
    logic [WIDTHA-1:0] ftw_pending_r;

    // Stage 1
    logic [WIDTHA-1:0] acc_r;
    logic              carry1_r;
    logic [WIDTHT-1:0] pow1_r;
    logic [15:0]       lfsr_r;
    logic              v1_r;

    // Stage 2 (only the bits surviving truncation are kept)
    logic [WIDTHT-1:0] sum2_top_r;
    logic              carry2_r;
    logic [WIDTHT-1:0] pow2_r;
    logic              v2_r;

    // Stage 3 / outputs
    logic [WIDTHT-1:0] theta_r;
    logic              theta_valid_r;
    logic              wrap_r;

    // Combinational helpers
    logic              accept_s;
    logic              apply_s;
    logic [WIDTHA-1:0] ftw_eff_s;
    logic [WIDTHA-1:0] acc_sum_s;
    logic              acc_carry_s;
    logic [WIDTHA-1:0] dither_s;
    logic [WIDTHT-1:0] acc_hi_s;
    logic [LOWW-1:0]   acc_lo_s;
    logic [WIDTHT-1:0] dith_hi_s;
    logic [LOWW-1:0]   dith_lo_s;
    logic              lo_carry_s;
    logic [WIDTHT-1:0] sum2_top_s;

    // Handshake decode and stage-1 accumulator add.
    always_comb begin
        accept_s  = bus.ftw_valid & ~pend_r;
        // pend_r is registered, so a word accepted on this same edge cannot apply yet.
        apply_s   = bus.enable & pend_r;
        if (apply_s) begin
            ftw_eff_s = ftw_pending_r;
        end else begin
            ftw_eff_s = ftw_active_r;
        end
        {acc_carry_s, acc_sum_s} = {1'b0, acc_r} + {1'b0, ftw_eff_s};
    end

    // Stage-2 dithered sum, computed only for the retained upper bits.
    always_comb begin
        if (DITHER != 0) begin
            dither_s = {{(WIDTHA-16){1'b0}}, lfsr_r} << DSHIFT;
        end else begin
            dither_s = {WIDTHA{1'b0}};
        end
        acc_hi_s   = acc_r[WIDTHA-1 -: WIDTHT];
        acc_lo_s   = acc_r[LOWW-1:0];
        dith_hi_s  = dither_s[WIDTHA-1 -: WIDTHT];
        dith_lo_s  = dither_s[LOWW-1:0];
        // Carry out of the discarded low part: a + b overflows iff b > ~a.
        lo_carry_s = (dith_lo_s > ~acc_lo_s);
        sum2_top_s = acc_hi_s + dith_hi_s + {{(WIDTHT-1){1'b0}}, lo_carry_s};
    end

    // Tuning-word handshake: park accepted words, switch them in on the next strobe.
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            pend_r        <= 1'b0;
            ftw_active_r  <= {WIDTHA{1'b0}};
            ftw_pending_r <= {WIDTHA{1'b0}};
        end else begin
            if (apply_s) begin
                ftw_active_r <= ftw_pending_r;
                pend_r       <= 1'b0;
            end else if (accept_s) begin
                ftw_pending_r <= bus.ftw_data;
                pend_r        <= 1'b1;
            end else begin
                pend_r <= pend_r;
            end
        end
    end

    // Stage 1: accumulate, capture offset and carry, step the dither LFSR.
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            acc_r    <= {WIDTHA{1'b0}};
            carry1_r <= 1'b0;
            pow1_r   <= {WIDTHT{1'b0}};
            lfsr_r   <= LFSR_SEED;
            v1_r     <= 1'b0;
        end else begin
            v1_r <= bus.enable;
            if (bus.enable) begin
                if (bus.phase_sync) begin
                    acc_r    <= {WIDTHA{1'b0}};
                    carry1_r <= 1'b0;
                end else begin
                    acc_r    <= acc_sum_s;
                    carry1_r <= acc_carry_s;
                end
                pow1_r <= bus.pow_data;
                lfsr_r <= lfsr_next(lfsr_r);
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    // Stage 2: add dither below the truncation point, forward carry and offset.
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            sum2_top_r <= {WIDTHT{1'b0}};
            carry2_r   <= 1'b0;
            pow2_r     <= {WIDTHT{1'b0}};
            v2_r       <= 1'b0;
        end else begin
            v2_r <= v1_r;
            if (v1_r) begin
                sum2_top_r <= sum2_top_s;
                carry2_r   <= carry1_r;
                pow2_r     <= pow1_r;
            end else begin
                sum2_top_r <= sum2_top_r;
            end
        end
    end

    // Stage 3: apply phase offset; theta holds between valid samples.
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            theta_r       <= {WIDTHT{1'b0}};
            theta_valid_r <= 1'b0;
            wrap_r        <= 1'b0;
        end else begin
            theta_valid_r <= v2_r;
            wrap_r        <= v2_r & carry2_r;
            if (v2_r) begin
                theta_r <= sum2_top_r + pow2_r;
            end else begin
                theta_r <= theta_r;
            end
        end
    end

    assign bus.ftw_ready   = ~pend_r;
    assign bus.theta       = theta_r;
    assign bus.theta_valid = theta_valid_r;
    assign bus.wrap        = wrap_r;

endmodule

// File: tb/tb_nco_phase_accumulator.sv
// Self-checking bench for nco_phase_accumulator: a phase model in plain
// 64-bit arithmetic predicts every theta/wrap/valid/ready value; a second
// instance with dither enabled is checked for monotonic, bounded steps.
module tb_nco_phase_accumulator;
    localparam int WA = 32;
    localparam int WT = 11;

    logic clock = 1'b0;
    logic clock_areset_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    nco_phase_accumulator_if #(.WIDTHA(WA), .WIDTHT(WT)) bus ();
    nco_phase_accumulator_if #(.WIDTHA(WA), .WIDTHT(WT)) dbus ();

    nco_phase_accumulator #(.WIDTHA(WA), .WIDTHT(WT), .DITHER(0)) dut (
        .clock(clock), .clock_areset_n(clock_areset_n), .bus(bus));

    nco_phase_accumulator #(.WIDTHA(WA), .WIDTHT(WT), .DITHER(1)) dut_dither (
        .clock(clock), .clock_areset_n(clock_areset_n), .bus(dbus));

    typedef struct {
        int cyc_due;
        int theta;
        int wrap;
    } exp_t;

    exp_t             q[$];
    longint unsigned  m_acc, m_active, m_pending;
    bit               m_pend;
    int               cyc = 0;
    int               last_theta = 0;
    int               d_prev = 0;
    int               d_count = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_active = 0; m_pending = 0; m_pend = 0;
        q.delete();
        last_theta = 0;
        d_prev = 0;
    endtask

    // Phase model: what one clock edge does, given the inputs present at it.
    task automatic model_edge();
        longint unsigned w;
        longint unsigned s;
        int th, wr;
        bit acc_ok;
        acc_ok = bus.ftw_valid && !m_pend;
        if (bus.enable) begin
            w = m_active;
            if (m_pend) begin
                w = m_pending; m_active = m_pending; m_pend = 0;
            end
            if (bus.phase_sync) begin
                m_acc = 0; wr = 0;
            end else begin
                s = m_acc + w;
                wr = (s >= 64'h1_0000_0000) ? 1 : 0;
                m_acc = s % 64'h1_0000_0000;
            end
            th = int'(((m_acc >> (WA - WT)) + longint'(bus.pow_data)) % 2048);
            q.push_back('{cyc + 2, th, wr});
        end
        if (acc_ok) begin
            m_pending = longint'(bus.ftw_data); m_pend = 1;
        end
    endtask

    task automatic check_outputs();
        int t;
        chk("ready", bus.ftw_ready, !m_pend);
        if (q.size() > 0 && q[0].cyc_due == cyc) begin
            chk("valid", bus.theta_valid, 1);
            chk("theta", bus.theta, q[0].theta);
            chk("wrap", bus.wrap, q[0].wrap);
            last_theta = q[0].theta;
            void'(q.pop_front());
        end else begin
            chk("valid_idle", bus.theta_valid, 0);
            chk("wrap_idle", bus.wrap, 0);
            chk("theta_hold", bus.theta, last_theta);
        end
        if (dbus.theta_valid) begin
            t = int'(dbus.theta);
            if (dbus.wrap)
                chk("dither_wrap", {62'd0, d_prev == 2047, t == 0}, 64'd3);
            else
                chk("dither_step", (t == d_prev || t == d_prev + 1), 1);
            d_prev = t;
            d_count++;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        cyc++;
        model_edge();
        #1;
        check_outputs();
        @(negedge clock);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic hard_reset();
        #2 clock_areset_n = 1'b0;
        #1;
        chk("rst_theta", bus.theta, 0);
        chk("rst_valid", bus.theta_valid, 0);
        chk("rst_wrap", bus.wrap, 0);
        chk("rst_ready", bus.ftw_ready, 1);
        model_reset();
        @(negedge clock);
        clock_areset_n = 1'b1;
    endtask

    initial begin
        clock_areset_n  = 1'b0;
        bus.enable = 1'b0; bus.ftw_data = 32'd0; bus.ftw_valid = 1'b0;
        bus.pow_data = 11'd0; bus.phase_sync = 1'b0;
        dbus.enable = 1'b0; dbus.ftw_data = 32'd0; dbus.ftw_valid = 1'b0;
        dbus.pow_data = 11'd0; dbus.phase_sync = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        chk("init_theta", bus.theta, 0);
        chk("init_valid", bus.theta_valid, 0);
        chk("init_ready", bus.ftw_ready, 1);
        clock_areset_n = 1'b1;

        // 1: steady ramp, one theta LSB per sample, wrap on 2047 -> 0
        bus.ftw_data = 32'h0020_0000; bus.ftw_valid = 1'b1;
        tick();
        bus.ftw_valid = 1'b0; bus.enable = 1'b1;
        repeat (2052) tick();

        // 2: sparse strobes, word change lands on a sample boundary; second word refused
        for (int i = 0; i < 28; i++) begin
            bus.enable    = (i % 4 == 0);
            bus.ftw_valid = (i >= 1 && i <= 3);
            bus.ftw_data  = (i == 1) ? 32'h0040_0000 : 32'h1234_5678;
            tick();
        end
        bus.ftw_valid = 1'b0;

        // 3: zero tuning word, constant offset, one-edge offset change
        hard_reset();
        bus.enable = 1'b1; bus.pow_data = 11'h200;
        repeat (10) tick();
        bus.pow_data = 11'h7FF;
        tick();
        bus.pow_data = 11'h200;
        repeat (6) tick();

        // 4: phase_sync mid-run
        bus.enable = 1'b0; bus.ftw_data = 32'h0020_0000; bus.ftw_valid = 1'b1;
        tick();
        bus.ftw_valid = 1'b0; bus.enable = 1'b1; bus.pow_data = 11'h010;
        repeat (20) tick();
        bus.phase_sync = 1'b1;
        tick();
        bus.phase_sync = 1'b0;
        repeat (6) tick();

        // 5: reset with a pending word and samples in flight
        bus.enable = 1'b0; bus.ftw_data = 32'h0030_0000; bus.ftw_valid = 1'b1;
        tick();
        bus.ftw_valid = 1'b0;
        hard_reset();
        bus.pow_data = 11'd0; bus.enable = 1'b1;
        repeat (10) tick();

        // random traffic against the model
        for (int i = 0; i < 500; i++) begin
            bus.enable     = ($urandom_range(0, 3) != 0);
            bus.ftw_valid  = ($urandom_range(0, 5) == 0);
            bus.ftw_data   = $urandom;
            bus.pow_data   = 11'($urandom_range(0, 2047));
            bus.phase_sync = ($urandom_range(0, 31) == 0);
            tick();
        end
        bus.enable = 1'b0; bus.ftw_valid = 1'b0; bus.phase_sync = 1'b0;
        repeat (4) tick();

        // 6: dithered instance, quarter-LSB tuning word, 4096 samples
        hard_reset();
        d_count = 0;
        dbus.ftw_data = 32'h0008_0000; dbus.ftw_valid = 1'b1;
        tick();
        dbus.ftw_valid = 1'b0; dbus.enable = 1'b1;
        repeat (4096) tick();
        dbus.enable = 1'b0;
        repeat (4) tick();
        chk("dither_count", d_count, 4096);
        chk("dither_final", (d_prev >= 1023 && d_prev <= 1025), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
